// File: rtl/rib_xbar.sv
// rib_xbar: NM-master / NS-slave registered request/ack interconnect.
// A grant is held from arbitration until the slave acks, the decode misses or the timeout fires.
module rib_xbar #(
  parameter int NM = 4,
  parameter int NS = 6,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SEL_W = 4,
  parameter int ARB_MODE = 1,
  parameter int TIMEOUT = 255,
  parameter logic [NM-1:0] HOLD_MASK = 4'b1101
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NM*AW-1:0] m_addr_i,
  input  logic [NM*DW-1:0] m_data_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM-1:0]    m_req_i,
  output logic [NM*DW-1:0] m_data_o,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,
  output logic [NS*AW-1:0] s_addr_o,
  output logic [NS*DW-1:0] s_data_o,
  output logic [NS-1:0]    s_we_o,
  output logic [NS-1:0]    s_req_o,
  input  logic [NS*DW-1:0] s_data_i,
  input  logic [NS-1:0]    s_ack_i,
  output logic             hold_flag_o,
  output logic             busy_o
);

  localparam int GW = (NM > 1) ? $clog2(NM) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [SEL_W:0] NS_L = (SEL_W + 1)'(NS);
  localparam logic [AW-1:0] ADDR_MASK = {{SEL_W{1'b0}}, {(AW - SEL_W){1'b1}}};

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t           state_reg, state_next;
  logic [GW-1:0]    grant_reg, grant_next;
  logic [GW-1:0]    ptr_reg, ptr_next;
  logic [SEL_W-1:0] tgt_reg, tgt_next;
  logic [CW-1:0]    cnt_reg, cnt_next;

  logic [NM*DW-1:0] m_data_next;
  logic [NM-1:0]    m_ack_next, m_err_next;
  logic [NS*AW-1:0] s_addr_next;
  logic [NS*DW-1:0] s_data_next;
  logic [NS-1:0]    s_we_next, s_req_next;

  logic [AW-1:0] m_addr  [NM];
  logic [DW-1:0] m_wdata [NM];
  logic [DW-1:0] s_rdata [NS];

  genvar gi;
  generate
    for (gi = 0; gi < NM; gi++) begin : g_mst
      assign m_addr[gi]  = m_addr_i[gi*AW +: AW];
      assign m_wdata[gi] = m_data_i[gi*DW +: DW];
    end
    for (gi = 0; gi < NS; gi++) begin : g_slv
      assign s_rdata[gi] = s_data_i[gi*DW +: DW];
    end
  endgenerate

  assign hold_flag_o = |(m_req_i & HOLD_MASK);
  assign busy_o      = (state_reg != IDLE);

  // Arbitration winner and its decoded slave index
  logic [GW-1:0]    win;
  logic [SEL_W-1:0] win_tgt;
  logic             found;
  int               rr_idx;

  always_comb begin
    win    = '0;
    found  = 1'b0;
    rr_idx = 0;
    if (ARB_MODE == 0) begin
      for (int i = NM - 1; i >= 0; i--) begin
        if (m_req_i[i]) win = GW'(i);
      end
    end else begin
      for (int k = 1; k <= NM; k++) begin
        rr_idx = int'(ptr_reg) + k;
        if (rr_idx >= NM) rr_idx = rr_idx - NM;
        for (int i = 0; i < NM; i++) begin
          if (!found && i == rr_idx && m_req_i[i]) begin
            win   = GW'(i);
            found = 1'b1;
          end
        end
      end
    end
    win_tgt = '0;
    for (int i = 0; i < NM; i++) begin
      if (win == GW'(i)) win_tgt = m_addr[i][AW-1 -: SEL_W];
    end
  end

  // Response of the currently targeted slave; other lanes are ignored
  logic          tgt_ack;
  logic [DW-1:0] tgt_rdata;

  always_comb begin
    tgt_ack   = 1'b0;
    tgt_rdata = '0;
    for (int si = 0; si < NS; si++) begin
      if (tgt_reg == SEL_W'(si)) begin
        tgt_ack   = s_ack_i[si];
        tgt_rdata = s_rdata[si];
      end
    end
  end

  logic          resp_go, resp_err;
  logic [DW-1:0] resp_data;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_we;

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    ptr_next   = ptr_reg;
    tgt_next   = tgt_reg;
    cnt_next   = '0;
    resp_go    = 1'b0;
    resp_err   = 1'b0;
    resp_data  = '0;

    case (state_reg)
      IDLE: begin
        if (|m_req_i) begin
          grant_next = win;
          ptr_next   = win;
          tgt_next   = win_tgt;
          if ({1'b0, win_tgt} < NS_L) begin
            state_next = BUSY;
          end else begin
            state_next = RESP;
            resp_go    = 1'b1;
            resp_err   = 1'b1;
          end
        end
      end
      BUSY: begin
        if (tgt_ack) begin
          state_next = RESP;
          resp_go    = 1'b1;
          // only the target lane is live in BUSY, so this is the master's we
          resp_data  = (|s_we_o) ? '0 : tgt_rdata;
        end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
          state_next = RESP;
          resp_go    = 1'b1;
          resp_err   = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int mi = 0; mi < NM; mi++) begin
      if (grant_next == GW'(mi)) begin
        sel_addr  = m_addr[mi];
        sel_wdata = m_wdata[mi];
        sel_we    = m_we_i[mi];
      end
    end

    m_ack_next  = '0;
    m_err_next  = '0;
    m_data_next = '0;
    for (int mi = 0; mi < NM; mi++) begin
      if (resp_go && grant_next == GW'(mi)) begin
        m_ack_next[mi]             = 1'b1;
        m_err_next[mi]             = resp_err;
        m_data_next[mi*DW +: DW]   = resp_data;
      end
    end

    s_req_next  = '0;
    s_we_next   = '0;
    s_addr_next = '0;
    s_data_next = '0;
    if (state_next == BUSY) begin
      for (int si = 0; si < NS; si++) begin
        if (tgt_next == SEL_W'(si)) begin
          s_req_next[si]           = 1'b1;
          s_we_next[si]            = sel_we;
          s_addr_next[si*AW +: AW] = sel_addr & ADDR_MASK;
          s_data_next[si*DW +: DW] = sel_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      ptr_reg   <= GW'(NM - 1);
      tgt_reg   <= '0;
      cnt_reg   <= '0;
      m_ack_o   <= '0;
      m_err_o   <= '0;
      m_data_o  <= '0;
      s_req_o   <= '0;
      s_we_o    <= '0;
      s_addr_o  <= '0;
      s_data_o  <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
      tgt_reg   <= tgt_next;
      cnt_reg   <= cnt_next;
      m_ack_o   <= m_ack_next;
      m_err_o   <= m_err_next;
      m_data_o  <= m_data_next;
      s_req_o   <= s_req_next;
      s_we_o    <= s_we_next;
      s_addr_o  <= s_addr_next;
      s_data_o  <= s_data_next;
    end
  end

endmodule

// File: tb/tb_rib_xbar.sv
// Directed and random transactions against rib_xbar (NM=4, NS=6, round-robin, TIMEOUT=4),
// with expectations from a transaction-level reference model.
module tb_rib_xbar;
  localparam int NM = 4;
  localparam int NS = 6;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NM*AW-1:0] m_addr_i = '0;
  logic [NM*DW-1:0] m_data_i = '0;
  logic [NM-1:0]    m_we_i = '0;
  logic [NM-1:0]    m_req_i = '0;
  logic [NM*DW-1:0] m_data_o;
  logic [NM-1:0]    m_ack_o, m_err_o;
  logic [NS*AW-1:0] s_addr_o;
  logic [NS*DW-1:0] s_data_o;
  logic [NS-1:0]    s_we_o, s_req_o;
  logic [NS*DW-1:0] s_data_i = '0;
  logic [NS-1:0]    s_ack_i = '0;
  logic             hold_flag_o, busy_o;

  always #5 clk = ~clk;

  rib_xbar #(
    .NM(NM), .NS(NS), .AW(AW), .DW(DW), .SEL_W(4),
    .ARB_MODE(1), .TIMEOUT(TO), .HOLD_MASK(4'b1101)
  ) dut (
    .clk(clk), .rst(rst),
    .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_we_i(m_we_i), .m_req_i(m_req_i),
    .m_data_o(m_data_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o), .s_req_o(s_req_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .hold_flag_o(hold_flag_o), .busy_o(busy_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int rr_ptr = NM - 1;  // model: last granted master

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic [31:0] a, input logic [31:0] d, input logic we);
    m_addr_i[i*AW +: AW] = a;
    m_data_i[i*DW +: DW] = d;
    m_we_i[i] = we;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_s_req"},  256'(s_req_o),  256'(0));
    chk({tag, "_s_we"},   256'(s_we_o),   256'(0));
    chk({tag, "_s_addr"}, 256'(s_addr_o), 256'(0));
    chk({tag, "_s_data"}, 256'(s_data_o), 256'(0));
    chk({tag, "_m_ack"},  256'(m_ack_o),  256'(0));
    chk({tag, "_m_err"},  256'(m_err_o),  256'(0));
    chk({tag, "_m_data"}, 256'(m_data_o), 256'(0));
    chk({tag, "_busy"},   256'(busy_o),   256'(0));
  endtask

  // Model: first requester after the last grant, cyclic.
  function automatic int pick(input logic [NM-1:0] reqs);
    for (int k = 1; k <= NM; k++) begin
      if (reqs[(rr_ptr + k) % NM]) return (rr_ptr + k) % NM;
    end
    return 0;
  endfunction

  // One transaction starting in an IDLE cycle. dly = BUSY cycle index of the slave ack, -1 = never.
  task automatic run_txn(input logic [NM-1:0] reqs, input int exp_w, input int dly, input logic [31:0] rd);
    logic [31:0]      a;
    logic             we;
    logic             hold_exp;
    int               t, nb;
    bit               tout;
    logic [NS*AW-1:0] ea;
    logic [NS*DW-1:0] ed;
    logic [NS-1:0]    ew, er, noise;
    logic [NM-1:0]    eack, eerr;
    logic [NM*DW-1:0] emd;
    logic [31:0]      rdata;

    m_req_i = reqs;
    #1;
    hold_exp = |(reqs & 4'b1101);
    chk("hold_flag", 256'(hold_flag_o), 256'(hold_exp));
    chk("idle_busy", 256'(busy_o), 256'(0));
    a  = m_addr_i[exp_w*AW +: AW];
    we = m_we_i[exp_w];
    t  = int'(a[31:28]);
    rr_ptr = exp_w;
    eack = '0;
    eack[exp_w] = 1'b1;
    rdata = '0;
    step();

    if (t >= NS) begin
      chk("miss_ack",  256'(m_ack_o),  256'(eack));
      chk("miss_err",  256'(m_err_o),  256'(eack));
      chk("miss_data", 256'(m_data_o), 256'(0));
      chk("miss_sreq", 256'(s_req_o),  256'(0));
    end else begin
      tout = !(dly >= 0 && dly < TO);
      nb   = tout ? TO : dly + 1;
      ea = '0; ed = '0; ew = '0; er = '0;
      ea[t*AW +: AW] = {4'h0, a[27:0]};
      ed[t*DW +: DW] = m_data_i[exp_w*DW +: DW];
      ew[t] = we;
      er[t] = 1'b1;
      for (int k = 0; k < nb; k++) begin
        chk("busy_sreq",  256'(s_req_o),  256'(er));
        chk("busy_saddr", 256'(s_addr_o), 256'(ea));
        chk("busy_sdata", 256'(s_data_o), 256'(ed));
        chk("busy_swe",   256'(s_we_o),   256'(ew));
        chk("busy_mack",  256'(m_ack_o),  256'(0));
        chk("busy_flag",  256'(busy_o),   256'(1));
        for (int l = 0; l < NS; l++) s_data_i[l*DW +: DW] = $urandom;
        noise = NS'($urandom);
        noise[t] = 1'b0;
        if (!tout && k == dly) begin
          s_data_i[t*DW +: DW] = rd;
          rdata = rd;
          noise[t] = 1'b1;
        end
        s_ack_i = noise;
        step();
      end
      s_ack_i = '0;
      eerr = tout ? eack : '0;
      emd = '0;
      if (!tout && !we) emd[exp_w*DW +: DW] = rdata;
      chk("resp_ack",  256'(m_ack_o),  256'(eack));
      chk("resp_err",  256'(m_err_o),  256'(eerr));
      chk("resp_data", 256'(m_data_o), 256'(emd));
      chk("resp_sreq", 256'(s_req_o),  256'(0));
    end
    step();
    chk("post_ack",  256'(m_ack_o), 256'(0));
    chk("post_busy", 256'(busy_o),  256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NM-1:0] reqs;
    int            dly;

    // Reset state
    step();
    step();
    chk_zero("reset");
    rst = 1'b1;
    step();
    chk("reset_idle", 256'(busy_o), 256'(0));

    // Round-robin alternation between masters 0 and 2
    set_m(0, 32'h0000_0010, 32'hA000_0000, 1'b0);
    set_m(2, 32'h2000_0020, 32'hA000_0002, 1'b0);
    run_txn(4'b0101, 0, 0, 32'h1111_0000);
    run_txn(4'b0101, 2, 0, 32'h1111_0002);
    run_txn(4'b0101, 0, 0, 32'h1111_0010);
    run_txn(4'b0101, 2, 0, 32'h1111_0012);

    // Read through slave 1 with address MSBs stripped
    set_m(1, 32'h1000_0040, 32'h0, 1'b0);
    run_txn(4'b0010, 1, 0, 32'hDEAD_BEEF);

    // Decode miss
    set_m(0, 32'h7000_0000, 32'h0, 1'b0);
    run_txn(4'b0001, 0, 0, 32'h0);

    // Timeouts back to back, then an ack in the last allowed cycle
    set_m(2, 32'h3000_0000, 32'h0, 1'b0);
    run_txn(4'b0100, 2, -1, 32'h0);
    run_txn(4'b0100, 2, -1, 32'h0);
    run_txn(4'b0100, 2, TO - 1, 32'h5A5A_A5A5);

    // Write to slave 5; hold flag on master 3, not on master 1
    set_m(3, 32'h5000_0008, 32'h1234_5678, 1'b1);
    run_txn(4'b1000, 3, 2, 32'hFFFF_FFFF);
    set_m(1, 32'h4000_0004, 32'h0, 1'b0);
    run_txn(4'b0010, 1, 1, 32'h0BAD_F00D);

    // Reset in the middle of a transaction
    set_m(3, 32'h3000_0000, 32'h0, 1'b0);
    m_req_i = 4'b1010;
    step();
    chk("pre_reset_busy", 256'(busy_o), 256'(1));
    rst = 1'b0;
    #1;
    chk_zero("midreset");
    m_req_i = '0;
    step();
    step();
    rst = 1'b1;
    rr_ptr = NM - 1;
    step();
    chk_zero("after_reset");
    set_m(0, 32'h0000_0100, 32'h0, 1'b0);
    set_m(2, 32'h2000_0200, 32'h0, 1'b0);
    run_txn(4'b0101, 0, 0, 32'hCAFE_0000);

    // Random transactions against the model
    repeat (40) begin
      reqs = NM'($urandom_range(1, 15));
      for (int i = 0; i < NM; i++) begin
        set_m(i, {4'($urandom_range(0, 7)), 28'($urandom)}, $urandom, 1'($urandom));
      end
      dly = int'($urandom_range(0, 6)) - 1;
      run_txn(reqs, pick(reqs), dly, $urandom);
    end
    m_req_i = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
